// File: rtl/signed_add_arbiter.sv
// Two requesters share one signed adder through a round-robin arbiter; the result,
// its overflow flag and the winner ID sit in a single registered output stage.
module signed_add_arbiter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid_i,
    input  logic [WIDTH-1:0] req0_a_i,
    input  logic [WIDTH-1:0] req0_b_i,
    output logic             req0_ready_o,
    input  logic             req1_valid_i,
    input  logic [WIDTH-1:0] req1_a_i,
    input  logic [WIDTH-1:0] req1_b_i,
    output logic             req1_ready_o,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [WIDTH-1:0] res_sum_o,
    output logic             res_overflow_o,
    output logic             res_id_o,
    output logic [CNT_W-1:0] ovf_count_o
);

    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_sum_q, res_sum_d;
    logic             res_ovf_q, res_ovf_d;
    logic             res_id_q, res_id_d;
    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             can_load, prio0, prio1, xfer0, xfer1, load;
    logic [WIDTH-1:0] op_a, op_b, sum;
    logic             ovf;

    // Priority goes to whoever did not win the last transfer; an idle peer never blocks.
    always_comb begin
        can_load = !res_valid_q | res_ready_i;
        prio0    = !req1_valid_i | last_grant_q;
        prio1    = !req0_valid_i | !last_grant_q;
    end

    assign req0_ready_o = can_load & prio0;
    assign req1_ready_o = can_load & prio1;

    always_comb begin
        xfer0 = req0_valid_i & req0_ready_o;
        xfer1 = req1_valid_i & req1_ready_o;
        load  = xfer0 | xfer1;
        op_a  = xfer1 ? req1_a_i : req0_a_i;
        op_b  = xfer1 ? req1_b_i : req0_b_i;
        sum   = op_a + op_b;
        ovf   = (op_a[WIDTH-1] == op_b[WIDTH-1]) & (sum[WIDTH-1] != op_a[WIDTH-1]);
    end

    always_comb begin
        res_valid_d  = res_valid_q;
        res_sum_d    = res_sum_q;
        res_ovf_d    = res_ovf_q;
        res_id_d     = res_id_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        if (load) begin
            res_valid_d  = 1'b1;
            res_sum_d    = sum;
            res_ovf_d    = ovf;
            res_id_d     = xfer1;
            last_grant_d = xfer1;
            if (ovf && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else if (res_ready_i) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q  <= 1'b0;
            res_sum_q    <= '0;
            res_ovf_q    <= 1'b0;
            res_id_q     <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
        end else begin
            res_valid_q  <= res_valid_d;
            res_sum_q    <= res_sum_d;
            res_ovf_q    <= res_ovf_d;
            res_id_q     <= res_id_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

    assign res_valid_o    = res_valid_q;
    assign res_sum_o      = res_sum_q;
    assign res_overflow_o = res_ovf_q;
    assign res_id_o       = res_id_q;
    assign ovf_count_o    = cnt_q;

endmodule

// File: tb/tb_signed_add_arbiter.sv
// Directed bench for signed_add_arbiter (WIDTH=4, CNT_W=2) with hand-computed expectations.
module tb_signed_add_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req0_valid, req1_valid, req0_ready, req1_ready;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic       res_valid, res_ready, res_overflow, res_id;
    logic [3:0] res_sum;
    logic [1:0] ovf_count;

    int checks = 0;
    int errors = 0;

    signed_add_arbiter #(
        .WIDTH(4),
        .CNT_W(2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req0_valid_i  (req0_valid),
        .req0_a_i      (req0_a),
        .req0_b_i      (req0_b),
        .req0_ready_o  (req0_ready),
        .req1_valid_i  (req1_valid),
        .req1_a_i      (req1_a),
        .req1_b_i      (req1_b),
        .req1_ready_o  (req1_ready),
        .res_valid_o   (res_valid),
        .res_ready_i   (res_ready),
        .res_sum_o     (res_sum),
        .res_overflow_o(res_overflow),
        .res_id_o      (res_id),
        .ovf_count_o   (ovf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {valid, id, overflow, sum}
    function automatic logic [6:0] res_vec();
        return {res_valid, res_id, res_overflow, res_sum};
    endfunction

    task automatic apply_reset();
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        res_ready  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (res_vec() !== 7'b0 || ovf_count !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got res=%b cnt=%0d, want res=0000000 cnt=0",
                     res_vec(), ovf_count);
        end
    endtask

    task automatic test_overflow();
        logic [3:0] va [3] = '{4'b0111, 4'b1000, 4'b0011};
        logic [3:0] vb [3] = '{4'b0001, 4'b1111, 4'b1110};
        logic [6:0] ve [3] = '{7'b1011000, 7'b1010111, 7'b1000001};
        logic [1:0] vc [3] = '{2'd1, 2'd2, 2'd2};
        for (int i = 0; i < 3; i++) begin
            req0_valid = 1'b1; req0_a = va[i]; req0_b = vb[i];
            #1;
            checks++;
            if (req0_ready !== 1'b1) begin
                errors++;
                $display("FAIL ovf_ready[%0d]: got %b, want 1", i, req0_ready);
            end
            @(posedge clk); #1;
            checks++;
            if (res_vec() !== ve[i] || ovf_count !== vc[i]) begin
                errors++;
                $display("FAIL ovf_result[%0d]: got res=%b cnt=%0d, want res=%b cnt=%0d",
                         i, res_vec(), ovf_count, ve[i], vc[i]);
            end
        end
        req0_valid = 1'b0;
    endtask

    task automatic test_contention();
        logic [6:0] ve [4] = '{7'b1000011, 7'b1101011, 7'b1000011, 7'b1101011};
        logic [1:0] vr [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
        apply_reset();
        req0_a = 4'd1;  req0_b = 4'd2;   // 1 + 2 = 3
        req1_a = 4'd14; req1_b = 4'd13;  // -2 + -3 = -5
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ({req0_ready, req1_ready} !== vr[i]) begin
                errors++;
                $display("FAIL cont_ready[%0d]: got %b, want %b", i, {req0_ready, req1_ready}, vr[i]);
            end
            @(posedge clk); #1;
            checks++;
            if (res_vec() !== ve[i]) begin
                errors++;
                $display("FAIL cont_result[%0d]: got %b, want %b", i, res_vec(), ve[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        // Output holds id1 sum 1011 from the contention run; last_grant = 1.
        res_ready = 1'b0;
        req0_a = 4'd2; req0_b = 4'd3;    // 5
        req1_a = 4'd4; req1_b = 4'd4;    // 8, overflow
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({req0_ready, req1_ready} !== 2'b00) begin
                errors++;
                $display("FAIL bp_ready[%0d]: got %b, want 00", i, {req0_ready, req1_ready});
            end
            @(posedge clk); #1;
            checks++;
            if (res_vec() !== 7'b1101011) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got %b, want 1101011", i, res_vec());
            end
        end
        res_ready = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL bp_release_ready: got %b, want 10", {req0_ready, req1_ready});
        end
        @(posedge clk); #1;
        checks++;
        if (res_vec() !== 7'b1000101) begin
            errors++;
            $display("FAIL bp_release_result: got %b, want 1000101", res_vec());
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: got res_valid=%b, want 0", res_valid);
        end
    endtask

    task automatic test_single();
        req1_valid = 1'b1; req1_a = 4'd1; req1_b = 4'd1;   // 2
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (res_vec() !== 7'b1100010) begin
                errors++;
                $display("FAIL single_result[%0d]: got %b, want 1100010", i, res_vec());
            end
        end
        req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd3;   // 6
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL single_then_both_ready: got %b, want 10", {req0_ready, req1_ready});
        end
        @(posedge clk); #1;
        checks++;
        if (res_vec() !== 7'b1000110) begin
            errors++;
            $display("FAIL single_then_both_result: got %b, want 1000110", res_vec());
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_saturation();
        logic [1:0] vc [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        apply_reset();
        req0_valid = 1'b1; req0_a = 4'b0111; req0_b = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (ovf_count !== vc[i]) begin
                errors++;
                $display("FAIL sat_count[%0d]: got %0d, want %0d", i, ovf_count, vc[i]);
            end
        end
        req0_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        apply_reset();
        req0_valid = 1'b1; req0_a = 4'b0111; req0_b = 4'b0001;
        repeat (2) @(posedge clk);
        #1;
        req0_valid = 1'b0;
        res_ready  = 1'b0;
        checks++;
        if (res_valid !== 1'b1 || ovf_count !== 2'd2) begin
            errors++;
            $display("FAIL areset_pre: got valid=%b cnt=%0d, want valid=1 cnt=2", res_valid, ovf_count);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (res_valid !== 1'b0 || ovf_count !== 2'd0) begin
            errors++;
            $display("FAIL areset_now: got valid=%b cnt=%0d, want valid=0 cnt=0", res_valid, ovf_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        res_ready  = 1'b1;
        req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd1;
        req1_valid = 1'b1; req1_a = 4'd2; req1_b = 4'd2;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL areset_first_grant: got %b, want 10", {req0_ready, req1_ready});
        end
        @(posedge clk); #1;
        checks++;
        if (res_vec() !== 7'b1000010) begin
            errors++;
            $display("FAIL areset_first_result: got %b, want 1000010", res_vec());
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_overflow();
        test_contention();
        test_backpressure();
        test_single();
        test_saturation();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/signed_add_arbiter.md
# signed_add_arbiter

Shares one signed two's-complement adder with overflow detection between two requesters. Each requester presents an operand pair under a valid/ready handshake. A round-robin arbiter picks one pair per cycle, and the block registers the sum, the overflow flag and the winner's ID into a single output stage, which is drained under its own valid/ready handshake. A saturating counter tracks overflow results for status readback.

## Interface
Parameters:
- WIDTH, 4, operand and sum width in bits (two's complement); legal ≥ 2
- CNT_W, 8, width of the overflow event counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operand pair
- req0_a, req0_b  in  WIDTH  requester 0 signed operands
- req0_ready  out  1  requester 0 transfer accepted this cycle if req0_valid
- req1_valid  in  1  requester 1 has an operand pair
- req1_a, req1_b  in  WIDTH  requester 1 signed operands
- req1_ready  out  1  requester 1 transfer accepted this cycle if req1_valid
- res_valid  out  1  output stage holds a result
- res_ready  in  1  consumer takes the result this cycle
- res_sum  out  WIDTH  a+b modulo 2^WIDTH
- res_overflow  out  1  signed overflow of res_sum
- res_id  out  1  requester that produced the result (0/1)
- ovf_count  out  CNT_W  saturating count of overflow results loaded

## Operation
- Reset is asynchronous and active-low; release is synchronous to clk.
  - Reset values: res_valid=0, res_sum=0, res_overflow=0, res_id=0, ovf_count=0, last_grant=1. With last_grant=1, requester 0 wins the first contention.
- can_load = !res_valid | res_ready. The output stage is empty or is being drained this cycle.
- Priority:
  - prio0 = !req1_valid | (last_grant==1)
  - prio1 = !req0_valid | (last_grant==0)
- Ready outputs:
  - req0_ready = can_load & prio0
  - req1_ready = can_load & prio1
  - Neither ready depends on its own valid.
  - When both valids are high, at most one ready is high.
- Transfer on requester i = req_i_valid & req_i_ready. At most one transfer occurs per cycle.
- On a transfer, at the clock edge:
  - res_sum <= a_i + b_i, truncated to WIDTH
  - res_overflow <= (a_i[MSB]==b_i[MSB]) & (sum[MSB]!=a_i[MSB])
  - res_id <= i
  - res_valid <= 1
  - last_grant <= i
- With no transfer and res_ready=1: res_valid <= 0. The data registers hold their old values.
- With res_valid=1 and res_ready=0: all output registers hold, and both readies are 0.
- last_grant changes only on a transfer. A single requester does not toggle fairness against an idle peer.
- ovf_count increments by 1 on each transfer whose computed overflow is 1. It saturates at 2^CNT_W-1 and never wraps.
- A result is counted once, at load, regardless of how long it waits in the output stage.

## Timing
- Latency is 1 cycle: operands accepted at edge k appear on res_* after edge k.
- Throughput is 1 result per cycle when res_ready is held at 1.
- Simultaneous drain and load in the same cycle: the new result replaces the old one and res_valid stays 1, with no bubble.
- Under continuous contention, grants alternate 0,1,0,1,… starting with 0 after reset.
- Output stability: while res_valid=1 and res_ready=0, res_sum, res_overflow and res_id are stable.
- Reset asserted mid-operation: the pending result is discarded immediately (asynchronously) and the counter clears. Any transfer in that cycle is lost.
- Combinational paths:
  - req*_valid → req*_ready (the other requester's ready)
  - res_ready → req*_ready
  - There is no path from inputs to res_*.

## Test plan
- Overflow cases (WIDTH=4), requester 0 alone, res_ready=1:
  - a=0111, b=0001 → one cycle later res_sum=1000, res_overflow=1, res_id=0, ovf_count=1
  - a=1000, b=1111 → res_sum=0111, res_overflow=1
  - a=0011, b=1110 → res_sum=0001, res_overflow=0
- Contention: both valid for 4 cycles with distinct operands and res_ready=1 → res_id sequence 0,1,0,1. Each result matches its requester's operands, and the readies are mutually exclusive each cycle.
- Backpressure: load a result, then hold res_ready=0 for 3 cycles with both requesters valid → both readies 0, res_* frozen. Raise res_ready → the next requester (round-robin) loads in the same cycle the old result drains, with no bubble.
- Single requester: req1 alone for 3 transfers, then both valid → res_id sequence 1,1,1 and then 0, because last_grant=1.
- Saturation: CNT_W=2, 5 overflowing transfers → ovf_count reads 1,2,3,3,3.
- Reset: assert rst_n=0 mid-cycle while res_valid=1 and ovf_count=2 → res_valid=0 and ovf_count=0 immediately, without waiting for a clock edge. After release, the first contention grants requester 0.
